// File: rtl/ext_fifo_pkg.sv
// Shared constants and helpers for the external-interface FIFO family.
package ext_fifo_pkg;

   localparam int unsigned EXT_FIFO_WIDTH      = 34;
   localparam int unsigned EXT_FIFO_DEPTH_LOG2 = 5;

   localparam int unsigned FIFO_MODE_REG  = 0;
   localparam int unsigned FIFO_MODE_FWFT = 1;

   // One extra bit beyond the address distinguishes full from empty.
   function automatic int unsigned ptr_width(input int unsigned depth_log2);
      return depth_log2 + 1;
   endfunction

endpackage

// File: rtl/ext_fifo_ram.sv
// Two-port storage array: synchronous write, asynchronous read, never reset.
module ext_fifo_ram #(
   parameter int unsigned WIDTH      = 34,
   parameter int unsigned DEPTH_LOG2 = 5
) (
   input  logic                  clk,
   input  logic                  i_wr_en,
   input  logic [DEPTH_LOG2-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]      i_wr_data,
   input  logic [DEPTH_LOG2-1:0] i_rd_addr,
   output logic [WIDTH-1:0]      o_rd_data
);

   logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];

   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ext_fifo_pro.sv
// Single-clock guarded FIFO with occupancy, threshold flags, sticky errors and
// selectable first-word-fall-through or registered read data.
module ext_fifo_pro
   import ext_fifo_pkg::*;
#(
   parameter int unsigned WIDTH      = EXT_FIFO_WIDTH,
   parameter int unsigned DEPTH_LOG2 = EXT_FIFO_DEPTH_LOG2,
   parameter int unsigned FWFT       = FIFO_MODE_FWFT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      wr_data_i,
   input  logic                  wr_en_i,
   input  logic                  rd_en_i,
   output logic [WIDTH-1:0]      rd_data_o,
   output logic                  rd_valid_o,
   output logic                  full_o,
   output logic                  empty_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o,
   input  logic [DEPTH_LOG2:0]   af_thresh_i,
   input  logic [DEPTH_LOG2:0]   ae_thresh_i,
   output logic [DEPTH_LOG2:0]   count_o,
   output logic                  overflow_o,
   output logic                  underflow_o,
   input  logic                  err_clr_i
);

   localparam int unsigned PW = ptr_width(DEPTH_LOG2);
   localparam logic [PW-1:0] CAP = PW'(2**DEPTH_LOG2);

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [PW-1:0]    r_count;
   logic             r_overflow;
   logic             r_underflow;
   logic             w_rd_acc;
   logic             w_wr_acc;
   logic             w_empty;
   logic             w_full;
   logic [WIDTH-1:0] w_ram_rd_data;

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CAP);
   assign w_rd_acc = rd_en_i & ~w_empty;
   // A write into a full FIFO only fits if a read frees a slot this cycle.
   assign w_wr_acc = wr_en_i & (~w_full | w_rd_acc);

   ext_fifo_ram #(
      .WIDTH      (WIDTH),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_wr_acc),
      .i_wr_addr (r_wr_ptr[DEPTH_LOG2-1:0]),
      .i_wr_data (wr_data_i),
      .i_rd_addr (r_rd_ptr[DEPTH_LOG2-1:0]),
      .o_rd_data (w_ram_rd_data)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         unique case ({w_wr_acc, w_rd_acc})
            2'b10:   r_count <= r_count + PW'(1);
            2'b01:   r_count <= r_count - PW'(1);
            default: r_count <= r_count;
         endcase
         // Set has priority over a same-cycle clear.
         r_overflow  <= (wr_en_i & ~w_wr_acc) | (r_overflow & ~err_clr_i);
         r_underflow <= (rd_en_i & ~w_rd_acc) | (r_underflow & ~err_clr_i);
      end
   end

   assign count_o        = r_count;
   assign empty_o        = w_empty;
   assign full_o         = w_full;
   assign almost_full_o  = (r_count >= af_thresh_i);
   assign almost_empty_o = (r_count <= ae_thresh_i);
   assign overflow_o     = r_overflow;
   assign underflow_o    = r_underflow;

   if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign rd_data_o  = w_empty ? '0 : w_ram_rd_data;
      assign rd_valid_o = ~w_empty;
   end else begin : g_reg
      logic [WIDTH-1:0] r_rd_data;
      logic             r_rd_valid;

      always_ff @(posedge clk) begin
         if (!rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
         end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
               r_rd_data <= w_ram_rd_data;
            end
         end
      end

      assign rd_data_o  = r_rd_data;
      assign rd_valid_o = r_rd_valid;
   end

endmodule

// File: tb/tb_ext_fifo_pro.sv
// Drives an FWFT and a registered-mode FIFO with identical stimulus and checks
// both against a queue-based reference model.
module tb_ext_fifo_pro;

   localparam int unsigned W   = 8;
   localparam int unsigned DL  = 2;
   localparam int unsigned CAP = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  wr_data;
   logic          wr_en;
   logic          rd_en;
   logic          err_clr;
   logic [DL:0]   af_thresh;
   logic [DL:0]   ae_thresh;

   logic [W-1:0]  a_rd_data, b_rd_data;
   logic          a_rd_valid, b_rd_valid;
   logic          a_full, b_full, a_empty, b_empty;
   logic          a_af, b_af, a_ae, b_ae;
   logic [DL:0]   a_count, b_count;
   logic          a_ovf, b_ovf, a_unf, b_unf;

   int            n_cmp  = 0;
   int            n_fail = 0;

   // Reference model state
   logic [W-1:0]  q[$];
   logic          m_ovf = 1'b0;
   logic          m_unf = 1'b0;
   logic          m_valid = 1'b0;
   logic [W-1:0]  m_rdata = '0;

   always #5 clk = ~clk;

   ext_fifo_pro #(.WIDTH(W), .DEPTH_LOG2(DL), .FWFT(1)) u_fwft (
      .clk            (clk),
      .rst            (rst),
      .wr_data_i      (wr_data),
      .wr_en_i        (wr_en),
      .rd_en_i        (rd_en),
      .rd_data_o      (a_rd_data),
      .rd_valid_o     (a_rd_valid),
      .full_o         (a_full),
      .empty_o        (a_empty),
      .almost_full_o  (a_af),
      .almost_empty_o (a_ae),
      .af_thresh_i    (af_thresh),
      .ae_thresh_i    (ae_thresh),
      .count_o        (a_count),
      .overflow_o     (a_ovf),
      .underflow_o    (a_unf),
      .err_clr_i      (err_clr)
   );

   ext_fifo_pro #(.WIDTH(W), .DEPTH_LOG2(DL), .FWFT(0)) u_reg (
      .clk            (clk),
      .rst            (rst),
      .wr_data_i      (wr_data),
      .wr_en_i        (wr_en),
      .rd_en_i        (rd_en),
      .rd_data_o      (b_rd_data),
      .rd_valid_o     (b_rd_valid),
      .full_o         (b_full),
      .empty_o        (b_empty),
      .almost_full_o  (b_af),
      .almost_empty_o (b_ae),
      .af_thresh_i    (af_thresh),
      .ae_thresh_i    (ae_thresh),
      .count_o        (b_count),
      .overflow_o     (b_ovf),
      .underflow_o    (b_unf),
      .err_clr_i      (err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string step);
      int          n;
      logic [W-1:0] head;
      n    = q.size();
      head = '0;
      if (n > 0) head = q[0];
      chk({step, ":count_a"}, 32'(a_count), 32'(n));
      chk({step, ":count_b"}, 32'(b_count), 32'(n));
      chk({step, ":empty"}, {30'd0, a_empty, b_empty}, {30'd0, n == 0, n == 0});
      chk({step, ":full"}, {30'd0, a_full, b_full}, {30'd0, n == CAP, n == CAP});
      chk({step, ":afull"}, {30'd0, a_af, b_af},
          {30'd0, n >= int'(af_thresh), n >= int'(af_thresh)});
      chk({step, ":aempty"}, {30'd0, a_ae, b_ae},
          {30'd0, n <= int'(ae_thresh), n <= int'(ae_thresh)});
      chk({step, ":ovf"}, {30'd0, a_ovf, b_ovf}, {30'd0, m_ovf, m_ovf});
      chk({step, ":unf"}, {30'd0, a_unf, b_unf}, {30'd0, m_unf, m_unf});
      chk({step, ":fwft_data"}, 32'(a_rd_data), 32'(head));
      chk({step, ":fwft_valid"}, 32'(a_rd_valid), 32'(n > 0));
      chk({step, ":reg_valid"}, 32'(b_rd_valid), 32'(m_valid));
      chk({step, ":reg_data"}, 32'(b_rd_data), 32'(m_rdata));
   endtask

   // Apply one cycle of stimulus, clock it, advance the model, then check.
   task automatic cycle(input string step, input logic r, input logic we, input logic [W-1:0] wd,
                        input logic re, input logic clr);
      logic         racc, wacc;
      logic [W-1:0] popped;
      rst     = r;
      wr_en   = we;
      wr_data = wd;
      rd_en   = re;
      err_clr = clr;
      @(posedge clk);
      #1;
      if (!r) begin
         q.delete();
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
         m_valid = 1'b0;
         m_rdata = '0;
      end else begin
         racc  = re && (q.size() > 0);
         wacc  = we && ((q.size() < CAP) || racc);
         m_ovf = (we && !wacc) || (m_ovf && !clr);
         m_unf = (re && !racc) || (m_unf && !clr);
         m_valid = racc;
         if (racc) begin
            popped  = q.pop_front();
            m_rdata = popped;
         end
         if (wacc) q.push_back(wd);
      end
      check_all(step);
   endtask

   initial begin
      rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; wr_data = '0;
      af_thresh = 3'd3;
      ae_thresh = 3'd1;

      cycle("reset0", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      cycle("reset1", 1'b0, 1'b1, 8'hEE, 1'b1, 1'b0);

      // Fill then drain; thresholds exercised at every count on the way
      cycle("fill11", 1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
      cycle("fill22", 1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
      cycle("fill33", 1'b1, 1'b1, 8'h33, 1'b0, 1'b0);
      cycle("fill44", 1'b1, 1'b1, 8'h44, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cycle("drain", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

      // Overflow on full, then clear
      for (int i = 0; i < 4; i++) cycle("refill", 1'b1, 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      cycle("ovf_wr", 1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
      cycle("ovf_hold", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      cycle("ovf_clr", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
      // Set wins over same-cycle clear
      cycle("ovf_setclr", 1'b1, 1'b1, 8'h56, 1'b0, 1'b1);
      cycle("ovf_clr2", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);

      // Simultaneous read/write when full, then when empty
      cycle("full_rw", 1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) cycle("drain2", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      cycle("empty_rw", 1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
      cycle("empty_pop", 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);

      // Pointer wrap with one-at-a-time traffic
      for (int i = 0; i < 10; i++) begin
         cycle("wrap_wr", 1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
         cycle("wrap_rd", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      end

      // Registered mode latency, then reset mid-burst
      cycle("a5_wr", 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
      cycle("a5_rd", 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
      cycle("a5_idle", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      cycle("burst0", 1'b1, 1'b1, 8'hB0, 1'b0, 1'b0);
      cycle("burst1", 1'b1, 1'b1, 8'hB1, 1'b1, 1'b0);
      cycle("burst2", 1'b1, 1'b1, 8'hB2, 1'b1, 1'b0);
      cycle("rst_mid", 1'b0, 1'b1, 8'hB3, 1'b1, 1'b0);
      cycle("post_rst", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

      // Randomised traffic with randomised quasi-static thresholds
      for (int blk = 0; blk < 6; blk++) begin
         af_thresh = 3'($urandom_range(0, 4));
         ae_thresh = 3'($urandom_range(0, 4));
         for (int i = 0; i < 80; i++) begin
            cycle("rand", ($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 55),
                  8'($urandom), ($urandom_range(0, 99) < 50), ($urandom_range(0, 99) < 10));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
